// File: rtl/com_slink_diag_pkg.sv
// Shared encodings for the SLINK RX link-health monitor: link-state values and
// slink_err_vec bit positions.
package com_slink_diag_pkg;

   typedef enum logic [1:0] {
      ST_INIT     = 2'b00,
      ST_OK       = 2'b01,
      ST_DEGRADED = 2'b10,
      ST_FAIL     = 2'b11
   } link_state_e;

   // slink_err_vec layout: {break, delay, cause[num_cause-1:0]}
   function automatic int unsigned vec_dly_idx(input int unsigned num_cause);
      return num_cause;
   endfunction

   function automatic int unsigned vec_brk_idx(input int unsigned num_cause);
      return num_cause + 1;
   endfunction

endpackage

// File: rtl/com_slink_err_cnt.sv
// Saturating error counter with synchronous clear and a registered threshold flag.
// force_i ORs an extra condition into the flag register (used for the live delay level).
module com_slink_err_cnt
   import com_slink_diag_pkg::*;
#(
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned THRESHOLD = 10
) (
   input  logic             clk_125m,
   input  logic             rst_125m,
   input  logic             inc_i,
   input  logic             clr_i,
   input  logic             force_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             flag_o
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] ThrVal = CNT_W'(THRESHOLD);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flag_q, flag_d;

   // Clear beats a same-cycle increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
      flag_d = (cnt_q >= ThrVal) | force_i;
   end

   always_ff @(posedge clk_125m or negedge rst_125m) begin
      if (!rst_125m) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign flag_o = flag_q;

endmodule

// File: rtl/com_slink_diag_mc.sv
// Multi-cause SLINK RX link-health monitor: per-cause and delay fault counters, auto-clear
// after a run of clean packets, link-state FSM. COM_SLINK_DIAG_STAT_EN exposes err_cnt_bus.
module com_slink_diag_mc
   import com_slink_diag_pkg::*;
#(
   parameter int unsigned NUM_CAUSE     = 4,
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned ERR_THRESHOLD = 10,
   parameter int unsigned DLY_THRESHOLD = 100,
   parameter int unsigned OK_THRESHOLD  = 100,
   parameter int unsigned PIPE_DLY      = 2
) (
   input  logic                 clk_125m,
   input  logic                 rst_125m,
   input  logic                 chn_break_err,
   input  logic                 chn_pkt_eop,
   input  logic [NUM_CAUSE-1:0] chn_pkt_err,
   input  logic                 chn_pkt_delay_err,
   input  logic                 diag_clr,
   output logic                 slink_err,
   output logic [NUM_CAUSE+1:0] slink_err_vec,
   output logic [1:0]           link_state
`ifdef COM_SLINK_DIAG_STAT_EN
   ,
   output logic [(NUM_CAUSE+1)*CNT_W-1:0] err_cnt_bus
`endif
);

   localparam int          NCnt   = NUM_CAUSE + 1;
   localparam int unsigned DlyIdx = vec_dly_idx(NUM_CAUSE);
   localparam int unsigned BrkIdx = vec_brk_idx(NUM_CAUSE);
   localparam logic [CNT_W-1:0] OkThr = CNT_W'(OK_THRESHOLD);

   logic [NCnt-1:0]  inc_vec, force_vec, flag_vec;
   logic [CNT_W-1:0] cnt_arr [NCnt];

   logic                dly_d1_q, brk_q, err_clear_q, err_clear_d, clr_d1_q;
   logic [CNT_W-1:0]    ok_q, ok_d;
   logic [PIPE_DLY-1:0] pipe_q;
   link_state_e         state_q;

   logic pkt_err_any, clean_eop, cnt_clr, any_cnt_nz, fault_any;

   assign pkt_err_any = chn_pkt_eop & (|chn_pkt_err);
   assign clean_eop   = chn_pkt_eop & ~(|chn_pkt_err);
   assign cnt_clr     = err_clear_q | diag_clr;

   // Index NUM_CAUSE is the delay-episode counter, counted on the falling edge of the level
   assign inc_vec   = {dly_d1_q & ~chn_pkt_delay_err, {NUM_CAUSE{chn_pkt_eop}} & chn_pkt_err};
   assign force_vec = {dly_d1_q, {NUM_CAUSE{1'b0}}};

   for (genvar g = 0; g < NCnt; g++) begin : g_cnt
      com_slink_err_cnt #(
         .CNT_W    (CNT_W),
         .THRESHOLD((g < NUM_CAUSE) ? ERR_THRESHOLD : DLY_THRESHOLD)
      ) u_cnt (
         .clk_125m(clk_125m),
         .rst_125m(rst_125m),
         .inc_i   (inc_vec[g]),
         .clr_i   (cnt_clr),
         .force_i (force_vec[g]),
         .cnt_o   (cnt_arr[g]),
         .flag_o  (flag_vec[g])
      );
   end

   always_comb begin
      any_cnt_nz = 1'b0;
      for (int g = 0; g < NCnt; g++) begin
         any_cnt_nz = any_cnt_nz | (cnt_arr[g] != '0);
      end
   end

   always_comb begin
      ok_d = ok_q;
      if (diag_clr | pkt_err_any | dly_d1_q | chn_break_err) begin
         ok_d = '0;
      end else if (chn_pkt_eop && (ok_q != OkThr)) begin
         ok_d = ok_q + 1'b1;
      end
      err_clear_d = (ok_d == OkThr) && (ok_q != OkThr);
   end

   // Cause/delay flags lag their counters by a cycle, so they are stale while a clear is
   // being applied and on the cycle after; break is never masked.
   assign fault_any = brk_q | ((|flag_vec) & ~(cnt_clr | clr_d1_q));

   always_ff @(posedge clk_125m or negedge rst_125m) begin
      if (!rst_125m) begin
         dly_d1_q    <= 1'b0;
         brk_q       <= 1'b0;
         ok_q        <= '0;
         err_clear_q <= 1'b0;
         clr_d1_q    <= 1'b0;
      end else begin
         dly_d1_q    <= chn_pkt_delay_err;
         brk_q       <= chn_break_err;
         ok_q        <= ok_d;
         err_clear_q <= err_clear_d;
         clr_d1_q    <= cnt_clr;
      end
   end

   always_ff @(posedge clk_125m or negedge rst_125m) begin
      if (!rst_125m) begin
         state_q <= ST_INIT;
      end else if (diag_clr) begin
         state_q <= ST_INIT;
      end else if (fault_any) begin
         state_q <= ST_FAIL;
      end else begin
         unique case (state_q)
            ST_INIT:     if (clean_eop)   state_q <= ST_OK;
            ST_OK:       if (any_cnt_nz)  state_q <= ST_DEGRADED;
            ST_DEGRADED: if (err_clear_q) state_q <= ST_OK;
            ST_FAIL:     if (err_clear_q) state_q <= ST_OK;
            default:                      state_q <= ST_INIT;
         endcase
      end
   end

   assign slink_err_vec[NUM_CAUSE-1:0] = flag_vec[NUM_CAUSE-1:0];
   assign slink_err_vec[DlyIdx]        = flag_vec[NUM_CAUSE];
   assign slink_err_vec[BrkIdx]        = brk_q;

   always_ff @(posedge clk_125m or negedge rst_125m) begin
      if (!rst_125m) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= |slink_err_vec;
         for (int k = 1; k < PIPE_DLY; k++) begin
            pipe_q[k] <= pipe_q[k-1];
         end
      end
   end

   assign slink_err  = pipe_q[PIPE_DLY-1];
   assign link_state = state_q;

`ifdef COM_SLINK_DIAG_STAT_EN
   for (genvar g = 0; g < NCnt; g++) begin : g_bus
      assign err_cnt_bus[g*CNT_W +: CNT_W] = cnt_arr[g];
   end
`endif

endmodule
